// File: rtl/operand_move_unit_if.sv
// Handshake and data bundle between operand fetch, the operand move unit and writeback.
interface operand_move_unit_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MODE_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [MODE_W-1:0] mode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  s;
    logic              we;
    logic              err;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, s, we, err
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, s, we, err
    );
endinterface

// File: rtl/operand_move_unit.sv
// Registered MOVB/MOVA/MOVZ/MOVN/LUI operand mover with a 2-entry skid buffer
// so that in_ready is a flop and never depends on out_ready combinationally.
module operand_move_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MODE_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_move_unit_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_m_s;
    logic             r_m_we;
    logic             r_m_err;
    logic [WIDTH-1:0] r_k_s;
    logic             r_k_we;
    logic             r_k_err;
    logic             r_k_valid;

    logic [WIDTH-1:0] w_s;
    logic             w_we;
    logic             w_err;
    logic             w_acc;
    logic             w_xfer;

    always_comb begin
        w_s   = '0;
        w_we  = 1'b0;
        w_err = 1'b0;
        case (bus.mode)
            MODE_W'(0): begin w_s = bus.b; w_we = 1'b1; end
            MODE_W'(1): begin w_s = bus.a; w_we = 1'b1; end
            MODE_W'(2): begin w_s = bus.a; w_we = (bus.b == '0); end
            MODE_W'(3): begin w_s = bus.a; w_we = (bus.b != '0); end
            MODE_W'(4): begin
                w_s  = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                w_we = 1'b1;
            end
            default:    w_err = 1'b1;
        endcase
    end

    assign w_acc  = bus.in_valid & r_in_ready;
    assign w_xfer = r_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_m_s       <= '0;
            r_m_we      <= 1'b0;
            r_m_err     <= 1'b0;
            r_k_s       <= '0;
            r_k_we      <= 1'b0;
            r_k_err     <= 1'b0;
            r_k_valid   <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        r_m_s       <= w_s;
                        r_m_we      <= w_we;
                        r_m_err     <= w_err;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    if (w_acc && w_xfer) begin
                        r_m_s   <= w_s;
                        r_m_we  <= w_we;
                        r_m_err <= w_err;
                    end else if (w_acc) begin
                        // M is stalled downstream; park the newer result in K
                        r_k_s      <= w_s;
                        r_k_we     <= w_we;
                        r_k_err    <= w_err;
                        r_k_valid  <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= TWO;
                    end else if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_xfer) begin
                        r_m_s      <= r_k_s;
                        r_m_we     <= r_k_we;
                        r_m_err    <= r_k_err;
                        r_k_valid  <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= ONE;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_k_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_m_s;
    assign bus.we        = r_m_we;
    assign bus.err       = r_m_err;
endmodule

// File: tb/tb_operand_move_unit.sv
// Scoreboard bench for operand_move_unit at WIDTH=32 and WIDTH=16.
module tb_operand_move_unit;
    typedef struct {
        logic [31:0] s;
        logic        we;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q32[$];
    exp_t q16[$];

    operand_move_unit_if #(.WIDTH(32), .MODE_W(3)) bus32 ();
    operand_move_unit_if #(.WIDTH(16), .MODE_W(3)) bus16 ();

    operand_move_unit #(.WIDTH(32), .MODE_W(3)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32.slave)
    );
    operand_move_unit #(.WIDTH(16), .MODE_W(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one operand pair; returns at posedge+1 after it was accepted.
    task automatic send(input bit w16, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] mode, input logic [31:0] es,
                        input logic ewe, input logic eerr, output int stalls);
        exp_t e;
        bit   ok;
        e.s = es; e.we = ewe; e.err = eerr;
        stalls = 0;
        ok = 1'b0;
        if (w16) begin
            bus16.in_valid = 1'b1; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.mode = mode;
        end else begin
            bus32.in_valid = 1'b1; bus32.a = a; bus32.b = b; bus32.mode = mode;
        end
        while (!ok && stalls < 50) begin
            @(negedge clk);
            if ((w16 ? bus16.in_ready : bus32.in_ready) === 1'b1) ok = 1'b1;
            else stalls++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        if (ok) begin
            if (w16) q16.push_back(e);
            else q32.push_back(e);
        end
        #1;
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
    endtask

    logic        hold32 = 1'b0;
    logic [31:0] held32 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hold32 && bus32.out_valid) chk("hold32", bus32.s, held32);
            hold32 = bus32.out_valid && !bus32.out_ready;
            held32 = bus32.s;
            if (bus32.out_valid && bus32.out_ready) begin
                if (q32.size() == 0) chk("unexpected_out32", 32'd1, 32'd0);
                else begin
                    e = q32.pop_front();
                    chk("s32", bus32.s, e.s);
                    chk("we32", {31'd0, bus32.we}, {31'd0, e.we});
                    chk("err32", {31'd0, bus32.err}, {31'd0, e.err});
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus16.out_valid && bus16.out_ready) begin
            if (q16.size() == 0) chk("unexpected_out16", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                chk("s16", {16'd0, bus16.s}, e.s);
                chk("we16", {31'd0, bus16.we}, {31'd0, e.we});
                chk("err16", {31'd0, bus16.err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        int st;
        int stall_sum;
        bus32.in_valid = 1'b1; bus32.a = 32'h11111111; bus32.b = 32'hDEADBEEF;
        bus32.mode = 3'd0; bus32.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.mode = 3'd0;
        bus16.out_ready = 1'b1;

        // 1: reset with in_valid high, then first transaction
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus32.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus32.in_ready}, 32'd1);
        chk("rst_s", bus32.s, 32'd0);
        chk("rst_we_err", {30'd0, bus32.we, bus32.err}, 32'd0);
        bus32.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 32'h11111111, 32'hDEADBEEF, 3'd0, 32'hDEADBEEF, 1'b1, 1'b0, st);
        @(negedge clk);
        chk("latency1", {31'd0, bus32.out_valid}, 32'd1);
        @(posedge clk); #1;

        // 2: modes
        send(0, 32'h12345678, 32'd0,        3'd2, 32'h12345678, 1'b1, 1'b0, st);
        send(0, 32'h12345678, 32'd5,        3'd2, 32'h12345678, 1'b0, 1'b0, st);
        send(0, 32'h12345678, 32'd5,        3'd3, 32'h12345678, 1'b1, 1'b0, st);
        send(0, 32'h12345678, 32'h0000ABCD, 3'd4, 32'hABCD0000, 1'b1, 1'b0, st);
        send(0, 32'h12345678, 32'hFFFF1234, 3'd4, 32'h12340000, 1'b1, 1'b0, st);
        send(0, 32'h12345678, 32'd5,        3'd6, 32'd0,        1'b0, 1'b1, st);
        send(0, 32'h12345678, 32'd5,        3'd1, 32'h12345678, 1'b1, 1'b0, st);
        repeat (3) @(posedge clk); #1;

        // 3: backpressure
        bus32.out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++)
                    send(0, 32'h0, i, 3'd0, i, 1'b1, 1'b0, st);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready", {31'd0, bus32.in_ready}, 32'd0);
                chk("bp_s", bus32.s, 32'd1);
                repeat (2) @(negedge clk);
                chk("bp_s_held", bus32.s, 32'd1);
                @(posedge clk); #1;
                bus32.out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("bp_drained", q32.size(), 32'd0);

        // 4: full throughput
        stall_sum = 0;
        for (int i = 0; i < 16; i++) begin
            send(0, 32'h100 + i, 32'h0, 3'd1, 32'h100 + i, 1'b1, 1'b0, st);
            stall_sum += st;
        end
        chk("tp_stalls", stall_sum, 32'd0);
        repeat (3) @(posedge clk); #1;

        // 5: reset while holding two results
        bus32.out_ready = 1'b0;
        send(0, 32'h0, 32'hAAAA0001, 3'd0, 32'hAAAA0001, 1'b1, 1'b0, st);
        send(0, 32'h0, 32'hAAAA0002, 3'd0, 32'hAAAA0002, 1'b1, 1'b0, st);
        @(negedge clk);
        chk("two_in_ready", {31'd0, bus32.in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, bus32.out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, bus32.in_ready}, 32'd1);
        chk("mrst_s", bus32.s, 32'd0);
        q32.delete();
        #1 rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("mrst_no_stale", {31'd0, bus32.out_valid}, 32'd0);
        @(posedge clk); #1;

        // 6: WIDTH=16
        send(1, 32'h00AA, 32'h00CD, 3'd4, 32'hCD00, 1'b1, 1'b0, st);
        send(1, 32'h00AA, 32'h00CD, 3'd1, 32'h00AA, 1'b1, 1'b0, st);
        send(1, 32'h00AA, 32'h0000, 3'd3, 32'h00AA, 1'b0, 1'b0, st);

        for (int i = 0; i < 20 && (q32.size() != 0 || q16.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("final_drain32", q32.size(), 32'd0);
        chk("final_drain16", q16.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
